// File: rtl/fc_bias_requant.sv
// fc_bias_requant: per-lane bias add, rounding arithmetic right shift,
// optional ReLU and saturation for a LENGTH-lane FC accumulator stream.
// Two register stages that advance together under a valid/ready handshake.
// Stage 1 holds the biased sums and the per-beat controls.
// Stage 2 holds the requantised lanes and the saturation flag.
module fc_bias_requant #(
    parameter int BITWIDTH_DATA = 24,
    parameter int BITWIDTH_BIAS = 8,
    parameter int BITWIDTH_OUT  = 8,
    parameter int LENGTH        = 4,
    parameter int SHIFT_W       = 5,
    localparam int ADDR_W       = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [LENGTH-1:0][BITWIDTH_DATA-1:0]       data_in,
    input  logic [SHIFT_W-1:0]                         shift,
    input  logic                                       relu_en,
    input  logic                                       bias_we,
    input  logic [ADDR_W-1:0]                          bias_addr,
    input  logic [BITWIDTH_BIAS-1:0]                   bias_wdata,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [LENGTH-1:0][BITWIDTH_OUT-1:0]        result,
    output logic                                       sat_flag
);

    // Biased sum needs two guard bits so the largest data plus largest bias
    // cannot wrap.
    localparam int SUM_W  = BITWIDTH_DATA + 2;
    // The rounding constant can reach 2^(2^SHIFT_W - 2), so the rounding
    // datapath is widened to hold it alongside the sum without overflow.
    localparam int SPAN   = 1 << SHIFT_W;
    localparam int RND_W  = ((SUM_W > SPAN) ? SUM_W : SPAN) + 1;

    localparam logic [ADDR_W:0]         LEN_LIM  = (ADDR_W + 1)'(LENGTH);
    localparam logic [SHIFT_W-1:0]      SH_ZERO  = {SHIFT_W{1'b0}};
    localparam logic [SHIFT_W-1:0]      SH_ONE   = {{(SHIFT_W-1){1'b0}}, 1'b1};
    localparam logic signed [RND_W-1:0] RND_ZERO = {RND_W{1'b0}};
    localparam logic signed [RND_W-1:0] RND_ONE  = {{(RND_W-1){1'b0}}, 1'b1};
    localparam logic signed [RND_W-1:0] OUT_MAX  =
        {{(RND_W-BITWIDTH_OUT+1){1'b0}}, {(BITWIDTH_OUT-1){1'b1}}};
    localparam logic signed [RND_W-1:0] OUT_MIN  =
        {{(RND_W-BITWIDTH_OUT+1){1'b1}}, {(BITWIDTH_OUT-1){1'b0}}};

    // Bias bank
    logic signed [BITWIDTH_BIAS-1:0] r_bias [LENGTH];

    // Stage 1
    logic                            r_v1;
    logic signed [SUM_W-1:0]         r_sum [LENGTH];
    logic [SHIFT_W-1:0]              r_shift1;
    logic                            r_relu1;

    // Stage 2
    logic                                  r_out_valid;
    logic [LENGTH-1:0][BITWIDTH_OUT-1:0]   r_result;
    logic                                  r_sat;

    // Combinational datapath
    logic                            w_advance;
    logic                            w_accept;
    logic                            w_bias_wr_ok;
    logic signed [RND_W-1:0]         w_half;
    logic signed [RND_W-1:0]         w_ext  [LENGTH];
    logic signed [RND_W-1:0]         w_rq   [LENGTH];
    logic signed [RND_W-1:0]         w_act  [LENGTH];
    logic [BITWIDTH_OUT-1:0]         w_lane [LENGTH];
    logic                            w_clip [LENGTH];
    logic                            w_sat_any;

    assign w_advance    = ~r_out_valid | out_ready;
    assign w_accept     = in_valid & w_advance;
    assign w_bias_wr_ok = bias_we & ({1'b0, bias_addr} < LEN_LIM);

    assign in_ready  = w_advance;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign sat_flag  = r_sat;

    // Bias bank: out-of-range addresses are dropped; stage 1 reads the
    // pre-write value when a write and an acceptance share an edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LENGTH; i++) begin
                r_bias[i] <= {BITWIDTH_BIAS{1'b0}};
            end
        end else if (w_bias_wr_ok) begin
            r_bias[bias_addr] <= bias_wdata;
        end
    end

    // Stage 1: capture biased sums and per-beat controls on acceptance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v1     <= 1'b0;
            r_shift1 <= SH_ZERO;
            r_relu1  <= 1'b0;
            for (int i = 0; i < LENGTH; i++) begin
                r_sum[i] <= {SUM_W{1'b0}};
            end
        end else if (w_advance) begin
            r_v1 <= in_valid;
            if (w_accept) begin
                r_shift1 <= shift;
                r_relu1  <= relu_en;
                for (int i = 0; i < LENGTH; i++) begin
                    r_sum[i] <= $signed({{2{data_in[i][BITWIDTH_DATA-1]}}, data_in[i]})
                              + $signed({{(SUM_W-BITWIDTH_BIAS){r_bias[i][BITWIDTH_BIAS-1]}},
                                         r_bias[i]});
                end
            end
        end
    end

    // Requantise each stage-1 lane: round-half-up shift, ReLU, then clip.
    always_comb begin
        w_half    = RND_ONE <<< (r_shift1 - SH_ONE);
        w_sat_any = 1'b0;
        for (int i = 0; i < LENGTH; i++) begin
            w_ext[i] = {{(RND_W-SUM_W){r_sum[i][SUM_W-1]}}, r_sum[i]};
            if (r_shift1 == SH_ZERO) begin
                w_rq[i] = w_ext[i];
            end else begin
                w_rq[i] = (w_ext[i] + w_half) >>> r_shift1;
            end
            if (r_relu1 && w_rq[i][RND_W-1]) begin
                w_act[i] = RND_ZERO;
            end else begin
                w_act[i] = w_rq[i];
            end
            if (w_act[i] > OUT_MAX) begin
                w_lane[i] = OUT_MAX[BITWIDTH_OUT-1:0];
                w_clip[i] = 1'b1;
            end else if (w_act[i] < OUT_MIN) begin
                w_lane[i] = OUT_MIN[BITWIDTH_OUT-1:0];
                w_clip[i] = 1'b1;
            end else begin
                w_lane[i] = w_act[i][BITWIDTH_OUT-1:0];
                w_clip[i] = 1'b0;
            end
            w_sat_any = w_sat_any | w_clip[i];
        end
    end

    // Stage 2: present the requantised beat; hold it while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_result    <= {(LENGTH*BITWIDTH_OUT){1'b0}};
        end else if (w_advance) begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_sat <= w_sat_any;
                for (int i = 0; i < LENGTH; i++) begin
                    r_result[i] <= w_lane[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_bias_requant.sv
// Self-checking bench for fc_bias_requant: directed test-plan steps followed
// by randomised traffic, all checked against an arithmetic reference model.
module tb_fc_bias_requant;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [3:0][23:0] data_in;
    logic [4:0]       shift;
    logic             relu_en;
    logic             bias_we;
    logic [1:0]       bias_addr;
    logic [7:0]       bias_wdata;
    logic             out_valid;
    logic             out_ready;
    logic [3:0][7:0]  result;
    logic             sat_flag;

    int checks   = 0;
    int failures = 0;

    // Reference state: bias bank contents, expected out_valid timeline and
    // the ordered queue of expected output beats ({sat, lanes}).
    int          m_bias [4];
    bit          m_v1;
    bit          m_ov;
    logic [32:0] exp_q [$];
    logic [32:0] snap;
    bit          stalled;

    fc_bias_requant dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .shift      (shift),
        .relu_en    (relu_en),
        .bias_we    (bias_we),
        .bias_addr  (bias_addr),
        .bias_wdata (bias_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0][23:0] lanes(input int a, input int b, input int c, input int d);
        logic [3:0][23:0] v;
        v[0] = a[23:0];
        v[1] = b[23:0];
        v[2] = c[23:0];
        v[3] = d[23:0];
        return v;
    endfunction

    // Expected beat from plain integer arithmetic: floor((s + 2^(k-1)) / 2^k).
    function automatic logic [32:0] model(input logic [3:0][23:0] d, input int sh, input bit relu);
        logic [32:0] o;
        longint s, r, den, num;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            s = longint'($signed(d[i])) + longint'(m_bias[i]);
            if (sh == 0) begin
                r = s;
            end else begin
                den = longint'(1) << sh;
                num = s + den / 2;
                r   = num / den;
                if ((num % den != 0) && (num < 0)) r = r - 1;
            end
            if (relu && r < 0) r = 0;
            if (r > 127) begin
                r = 127;
                o[32] = 1'b1;
            end else if (r < -128) begin
                r = -128;
                o[32] = 1'b1;
            end
            o[i*8 +: 8] = r[7:0];
        end
        return o;
    endfunction

    // One clock cycle: drive, check against the model, then step the model.
    task automatic cyc(input bit v, input logic [3:0][23:0] d, input int sh, input bit relu,
                       input bit we, input int addr, input int wd, input bit ordy,
                       output bit acc);
        bit          adv;
        logic [32:0] e;
        in_valid   = v;
        data_in    = d;
        shift      = sh[4:0];
        relu_en    = relu;
        bias_we    = we;
        bias_addr  = addr[1:0];
        bias_wdata = wd[7:0];
        out_ready  = ordy;
        #1;
        adv = !m_ov || ordy;
        chk("in_ready", in_ready, adv);
        chk("out_valid", out_valid, m_ov);
        if (stalled) begin
            chk("stall_result", result, snap[31:0]);
            chk("stall_sat", sat_flag, snap[32]);
        end
        if (m_ov && ordy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL model_queue observed=empty expected=beat");
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e[31:0]);
                chk("sat_flag", sat_flag, e[32]);
            end
        end
        acc = v && adv;
        if (acc) exp_q.push_back(model(d, sh, relu));
        if (we && addr < 4) m_bias[addr] = int'($signed(wd[7:0]));
        stalled = m_ov && !ordy;
        snap    = {sat_flag, result};
        if (adv) begin
            m_ov = m_v1;
            m_v1 = acc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cyc(1'b0, lanes(0, 0, 0, 0), 0, 1'b0, 1'b0, 0, 0, 1'b1, a);
    endtask

    task automatic wr(input int addr, input int wd);
        bit a;
        cyc(1'b0, lanes(0, 0, 0, 0), 0, 1'b0, 1'b1, addr, wd, 1'b1, a);
    endtask

    task automatic beat(input logic [3:0][23:0] d, input int sh, input bit relu);
        bit a;
        cyc(1'b1, d, sh, relu, 1'b0, 0, 0, 1'b1, a);
        chk("beat_accepted", a, 1'b1);
    endtask

    initial begin
        logic [3:0][23:0] bb [5];
        logic signed [23:0] t;
        logic [3:0][23:0] rd;
        int bi;
        bit a;

        rstn = 1'b0;
        in_valid = 1'b0; data_in = '0; shift = '0; relu_en = 1'b0;
        bias_we = 1'b0; bias_addr = '0; bias_wdata = '0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) m_bias[i] = 0;
        m_v1 = 1'b0; m_ov = 1'b0; stalled = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_sat", sat_flag, 1'b0);
        chk("reset_result", result, 32'h0);
        rstn = 1'b1;

        // Latency / basic
        wr(1, 27);
        beat(lanes(5, 100, -7, 0), 0, 1'b0);
        idle(3);

        // Saturation both directions
        wr(1, 28);
        beat(lanes(0, 100, 0, 0), 0, 1'b0);
        beat(lanes(-200, 0, 0, 0), 0, 1'b0);
        wr(1, 0);
        idle(2);

        // Rounding, including maximum shift
        beat(lanes(40, -40, 24, -24), 4, 1'b0);
        beat(lanes(8388607, -8388608, 8388607, 1), 31, 1'b0);
        // ReLU without clipping
        beat(lanes(-5, -1000, 9, 0), 0, 1'b1);
        idle(3);

        // Backpressure: 5 back-to-back beats, out_ready low for cycles 3-5
        for (int i = 0; i < 5; i++) bb[i] = lanes(i * 3 + 1, -i * 7, i * 50, 100 - i);
        bi = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(bi < 5, bb[(bi < 5) ? bi : 0], 1, 1'b0, 1'b0, 0, 0, !(k >= 3 && k <= 5), a);
            if (a) bi++;
        end
        chk("bp_all_accepted", bi, 5);
        idle(2);

        // Bias write colliding with an accepted beat
        cyc(1'b1, lanes(0, 0, 1, 0), 0, 1'b0, 1'b1, 2, 10, 1'b1, a);
        chk("collide_accept", a, 1'b1);
        beat(lanes(0, 0, 1, 0), 0, 1'b0);
        idle(3);

        // Reset with two beats in flight
        beat(lanes(1, 2, 3, 4), 0, 1'b0);
        beat(lanes(5, 6, 7, 8), 0, 1'b0);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_async_out_valid", out_valid, 1'b0);
        m_v1 = 1'b0; m_ov = 1'b0; stalled = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) m_bias[i] = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(4);
        beat(lanes(0, 0, 1, 0), 0, 1'b0);
        idle(3);

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 4; i++) begin
                t = $urandom;
                t = t >>> $urandom_range(0, 23);
                rd[i] = t;
            end
            cyc($urandom_range(0, 3) != 0, rd, $urandom_range(0, 31), $urandom_range(0, 1) == 1,
                $urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, 255),
                $urandom_range(0, 3) != 0, a);
        end
        idle(6);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
